// File: rtl/board_store.sv
`default_nettype none
// ============================================================================
// board_store : 4x8 board state, canonical load and LFSR Fisher-Yates shuffle
// Revision    : 1.0
// ============================================================================
module board_store #(
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter bit          AUTO_SHUFFLE = 1'b1
) (
  input  logic         CLK,
  input  logic         RESET_N,
  input  logic         start_shuffle,
  input  logic         wr_en,
  input  logic [4:0]   wr_addr,
  input  logic [4:0]   wr_piece,
  output logic [159:0] board_output,
  output logic         ready,
  output logic         busy,
  output logic         shuffle_done
);

  typedef enum logic [2:0] {
    S_RST  = 3'd0,
    S_IDLE = 3'd1,
    S_LOAD = 3'd2,
    S_PICK = 3'd3,
    S_SWAP = 3'd4
  } state_t;

  localparam logic [15:0] C_LFSR_TAPS = 16'hB400;

  function automatic logic [159:0] canon_board();
    logic [159:0] b;
    logic [2:0]   t;
    int           lo;
    b = '0;
    for (int k = 0; k < 32; k++) begin
      lo = k % 16;
      if (lo <= 4)       t = 3'd1;
      else if (lo <= 6)  t = 3'd2;
      else if (lo <= 8)  t = 3'd3;
      else if (lo <= 10) t = 3'd4;
      else if (lo <= 12) t = 3'd5;
      else if (lo <= 14) t = 3'd6;
      else               t = 3'd7;
      b[k*5 +: 5] = {(k >= 16), t, 1'b0};
    end
    return b;
  endfunction

  localparam logic [159:0] C_CANON = canon_board();

  state_t       r_state;
  state_t       w_state_nxt;
  logic [15:0]  r_lfsr;
  logic [15:0]  w_lfsr_nxt;
  logic [159:0] r_board;
  logic [4:0]   r_i;
  logic [4:0]   r_j;
  logic [4:0]   w_mask;
  logic [4:0]   w_j;
  logic [7:0]   w_wr_base;
  logic [7:0]   w_i_base;
  logic [7:0]   w_j_base;

  assign w_lfsr_nxt = r_lfsr[0] ? ((r_lfsr >> 1) ^ C_LFSR_TAPS) : (r_lfsr >> 1);

  // Smallest all-ones mask covering i keeps the rejection rate below one half.
  always_comb begin
    w_mask = 5'd1;
    if (r_i >= 5'd16)     w_mask = 5'd31;
    else if (r_i >= 5'd8) w_mask = 5'd15;
    else if (r_i >= 5'd4) w_mask = 5'd7;
    else if (r_i >= 5'd2) w_mask = 5'd3;
  end

  assign w_j       = r_lfsr[4:0] & w_mask;
  assign w_wr_base = {3'b000, wr_addr} * 8'd5;
  assign w_i_base  = {3'b000, r_i} * 8'd5;
  assign w_j_base  = {3'b000, r_j} * 8'd5;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) r_state <= S_RST;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    ready        = 1'b0;
    busy         = 1'b0;
    shuffle_done = 1'b0;
    case (r_state)
      S_RST:  w_state_nxt = AUTO_SHUFFLE ? S_LOAD : S_IDLE;
      S_IDLE: begin
        ready = 1'b1;
        if (start_shuffle) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        busy        = 1'b1;
        w_state_nxt = S_PICK;
      end
      S_PICK: begin
        busy = 1'b1;
        if (w_j <= r_i) w_state_nxt = S_SWAP;
      end
      S_SWAP: begin
        busy = 1'b1;
        if (r_i == 5'd1) begin
          shuffle_done = 1'b1;
          w_state_nxt  = S_IDLE;
        end else begin
          w_state_nxt = S_PICK;
        end
      end
      default: w_state_nxt = S_RST;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_lfsr  <= LFSR_SEED;
      r_board <= C_CANON;
      r_i     <= 5'd31;
      r_j     <= 5'd0;
    end else begin
      r_lfsr <= w_lfsr_nxt;
      case (r_state)
        S_IDLE: begin
          if (!start_shuffle && wr_en) r_board[w_wr_base +: 5] <= wr_piece;
        end
        S_LOAD: begin
          r_board <= C_CANON;
          r_i     <= 5'd31;
        end
        S_PICK: begin
          if (w_j <= r_i) r_j <= w_j;
        end
        S_SWAP: begin
          r_board[w_i_base +: 5] <= r_board[w_j_base +: 5];
          r_board[w_j_base +: 5] <= r_board[w_i_base +: 5];
          if (r_i != 5'd1) r_i <= r_i - 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign board_output = r_board;

endmodule
`default_nettype wire

// File: tb/tb_board_store.sv
`default_nettype none
// ============================================================================
// tb_board_store : randomized scoreboard bench for board_store
// Revision       : 1.0
// ============================================================================
module tb_board_store;

  localparam logic [15:0] SEED = 16'hACE1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         rst_a_n = 1'b0;
  logic         start_shuffle = 1'b0;
  logic         wr_en = 1'b0;
  logic [4:0]   wr_addr = '0;
  logic [4:0]   wr_piece = '0;
  logic         zero1 = 1'b0;
  logic [4:0]   zero5 = '0;
  logic [159:0] board_output, board_a;
  logic         ready, busy, shuffle_done;
  logic         ready_a, busy_a, done_a;

  always #5 clk = ~clk;

  board_store #(.LFSR_SEED(SEED), .AUTO_SHUFFLE(1'b0)) dut (
    .CLK(clk), .RESET_N(rst_n), .start_shuffle(start_shuffle), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_piece(wr_piece), .board_output(board_output),
    .ready(ready), .busy(busy), .shuffle_done(shuffle_done)
  );

  board_store #(.LFSR_SEED(SEED), .AUTO_SHUFFLE(1'b1)) dut_a (
    .CLK(clk), .RESET_N(rst_a_n), .start_shuffle(zero1), .wr_en(zero1),
    .wr_addr(zero5), .wr_piece(zero5), .board_output(board_a),
    .ready(ready_a), .busy(busy_a), .shuffle_done(done_a)
  );

  typedef struct {
    int           due;
    logic [159:0] board;
    logic         rdy;
    logic         bsy;
    logic         ms;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_a_q[$];
  int   done_q[$];
  int   done_a_q[$];
  exp_t e_m, e_a;
  int   cyc = 0, cyc_a = 0;
  int   n_chk = 0, n_fail = 0;

  always @(posedge clk or negedge rst_n)   if (!rst_n)   cyc   <= 0; else cyc   <= cyc + 1;
  always @(posedge clk or negedge rst_a_n) if (!rst_a_n) cyc_a <= 0; else cyc_a <= cyc_a + 1;

  // ---------------- reference model ----------------
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic logic [15:0] lfsr_at(input int k);
    logic [15:0] v;
    v = SEED;
    for (int n = 0; n < k; n++) v = lfsr_step(v);
    return v;
  endfunction

  function automatic int mask_for(input int i);
    int m;
    m = 1;
    while (m < i) m = m * 2 + 1;
    return m;
  endfunction

  function automatic logic [159:0] canon_board();
    int           types[16];
    logic [159:0] b;
    logic [2:0]   t;
    types = '{1, 1, 1, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5, 6, 6, 7};
    b = '0;
    for (int i = 0; i < 32; i++) begin
      t = 3'(types[i % 16]);
      b[i*5 +: 5] = {(i >= 16), t, 1'b0};
    end
    return b;
  endfunction

  // Fisher-Yates with rejection; one LFSR value per cycle, LOAD at load_cyc.
  function automatic logic [159:0] shuffled(input int load_cyc, output int done_cyc);
    logic [159:0] b;
    logic [15:0]  v;
    logic [4:0]   tmp;
    int           pos, j;
    b = canon_board();
    pos = load_cyc + 1;
    v = lfsr_at(pos);
    done_cyc = 0;
    for (int i = 31; i >= 1; i--) begin
      j = int'(v[4:0]) & mask_for(i);
      v = lfsr_step(v); pos++;
      while (j > i) begin
        j = int'(v[4:0]) & mask_for(i);
        v = lfsr_step(v); pos++;
      end
      tmp = b[i*5 +: 5]; b[i*5 +: 5] = b[j*5 +: 5]; b[j*5 +: 5] = tmp;
      done_cyc = pos;
      v = lfsr_step(v); pos++;
    end
    return b;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [159:0] act, input logic [159:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic check_multiset(input string tag, input logic [159:0] b);
    int         cnt[2][8];
    int         want[8];
    logic [4:0] p;
    logic       st;
    want = '{0, 5, 2, 2, 2, 2, 2, 1};
    cnt = '{default: 0};
    st = 1'b0;
    for (int i = 0; i < 32; i++) begin
      p = b[i*5 +: 5];
      cnt[p[4]][p[3:1]]++;
      st = st | p[0];
    end
    check({tag, "_state_bits"}, 160'(st), 160'd0);
    for (int c = 0; c < 2; c++)
      for (int t = 1; t < 8; t++)
        check($sformatf("%s_count_c%0d_t%0d", tag, c, t), 160'(cnt[c][t]), 160'(want[t]));
    check({tag, "_differs_from_canon"}, 160'(b != canon_board()), 160'd1);
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
      n_chk++; n_fail++;
      $display("FAIL sb_missed: entry due cycle %0d not seen, now cycle %0d", exp_q[0].due, cyc);
      exp_q.delete(0);
    end
    while (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e_m = exp_q.pop_front();
      check($sformatf("board@%0d", cyc), board_output, e_m.board);
      check($sformatf("ready@%0d", cyc), 160'(ready), 160'(e_m.rdy));
      check($sformatf("busy@%0d", cyc), 160'(busy), 160'(e_m.bsy));
      if (e_m.ms) check_multiset("shuffle", board_output);
    end
    if (shuffle_done) begin
      if (done_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL done_unexpected: shuffle_done=1 at cycle %0d, expected 0", cyc);
      end else begin
        check("done_cycle", 160'(cyc), 160'(done_q.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    while (exp_a_q.size() > 0 && exp_a_q[0].due < cyc_a) begin
      n_chk++; n_fail++;
      $display("FAIL sb_a_missed: entry due cycle %0d not seen, now cycle %0d", exp_a_q[0].due, cyc_a);
      exp_a_q.delete(0);
    end
    while (exp_a_q.size() > 0 && exp_a_q[0].due == cyc_a) begin
      e_a = exp_a_q.pop_front();
      check($sformatf("auto_board@%0d", cyc_a), board_a, e_a.board);
      check($sformatf("auto_ready@%0d", cyc_a), 160'(ready_a), 160'(e_a.rdy));
      check($sformatf("auto_busy@%0d", cyc_a), 160'(busy_a), 160'(e_a.bsy));
      if (e_a.ms) check_multiset("auto_shuffle", board_a);
    end
    if (done_a) begin
      if (done_a_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL auto_done_unexpected: shuffle_done=1 at cycle %0d, expected 0", cyc_a);
      end else begin
        check("auto_done_cycle", 160'(cyc_a), 160'(done_a_q.pop_front()));
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [159:0] model_b;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_cyc(input int k);
    while (cyc < k) tick();
  endtask

  task automatic wait_cyc_a(input int k);
    while (cyc_a < k) tick();
  endtask

  task automatic push(input int due, input logic [159:0] b, input logic r, input logic bs, input logic ms);
    exp_t e;
    e.due = due; e.board = b; e.rdy = r; e.bsy = bs; e.ms = ms;
    exp_q.push_back(e);
  endtask

  task automatic push_a(input int due, input logic [159:0] b, input logic r, input logic bs, input logic ms);
    exp_t e;
    e.due = due; e.board = b; e.rdy = r; e.bsy = bs; e.ms = ms;
    exp_a_q.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; start_shuffle = 1'b0; wr_en = 1'b0;
    #1;
    model_b = canon_board();
    push(0, model_b, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    push(2, model_b, 1'b1, 1'b0, 1'b0);
  endtask

  // Pulses start at cycle k (optionally with a simultaneous write) and queues the outcome.
  task automatic shuffle_at(input int k, input logic with_wr, output int d);
    wait_cyc(k);
    start_shuffle = 1'b1;
    wr_en = with_wr; wr_addr = 5'd3; wr_piece = 5'h1F;
    push(k + 1, model_b, 1'b0, 1'b1, 1'b0);
    model_b = shuffled(k + 1, d);
    done_q.push_back(d);
    push(d + 1, model_b, 1'b1, 1'b0, 1'b1);
    tick();
    start_shuffle = 1'b0; wr_en = 1'b0;
  endtask

  initial begin
    int d, k, s;
    rst_n = 1'b0;
    #2;
    model_b = canon_board();
    push(0, model_b, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    push(2, model_b, 1'b1, 1'b0, 1'b0);

    // Directed write then a burst of random writes.
    wait_cyc(4);
    wr_en = 1'b1; wr_addr = 5'b01_010; wr_piece = 5'h13;
    model_b[10*5 +: 5] = 5'h13;
    push(cyc + 1, model_b, 1'b1, 1'b0, 1'b0);
    tick();
    for (int n = 0; n < 6; n++) begin
      wr_addr = 5'($urandom_range(0, 31));
      wr_piece = 5'($urandom_range(0, 31));
      model_b[int'(wr_addr)*5 +: 5] = wr_piece;
      push(cyc + 1, model_b, 1'b1, 1'b0, 1'b0);
      tick();
    end
    wr_en = 1'b0;

    // Shuffle with a write and a second start request issued while busy.
    k = cyc + 2;
    shuffle_at(k, 1'b0, d);
    wait_cyc(k + 6);
    wr_en = 1'b1; wr_addr = 5'b01_010; wr_piece = 5'h13;
    tick();
    wr_en = 1'b0;
    wait_cyc(k + 31);
    start_shuffle = 1'b1;
    tick();
    start_shuffle = 1'b0;
    wait_cyc(d + 3);

    // Write and start in the same IDLE cycle: write dropped.
    shuffle_at(cyc + 1, 1'b1, d);
    wait_cyc(d + 3);

    // Same start cycle after reset, then shifted by one, then random.
    s = 7;
    for (int n = 0; n < 3; n++) begin
      do_reset();
      shuffle_at((n == 2) ? int'($urandom_range(3, 40)) : s + n, 1'b0, d);
      wait_cyc(d + 3);
    end

    // Auto-shuffle instance: reset mid-shuffle, then a complete run.
    @(negedge clk);
    rst_a_n = 1'b1;
    push_a(1, canon_board(), 1'b0, 1'b1, 1'b0);
    void'(shuffled(1, d));
    done_a_q.push_back(d);
    wait_cyc_a(21);
    exp_a_q.delete();
    done_a_q.delete();
    rst_a_n = 1'b0;
    push_a(0, canon_board(), 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_a_n = 1'b1;
    push_a(1, canon_board(), 1'b0, 1'b1, 1'b0);
    model_b = shuffled(1, d);
    done_a_q.push_back(d);
    push_a(d + 1, model_b, 1'b1, 1'b0, 1'b1);
    wait_cyc_a(d + 3);

    check("sb_drained", 160'(exp_q.size() + done_q.size()), 160'd0);
    check("sb_a_drained", 160'(exp_a_q.size() + done_a_q.size()), 160'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
